// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-side master for the 32x32 register file.
// Merges ALU results (valid/ready) and load responses (no backpressure) into
// the single registered write port. Loads win collisions; ALU results that lose
// are buffered in a small in-order FIFO. Also keeps the pending-load scoreboard.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data  ALU result handshake
//   ld_issue/ld_issue_rd               load issued to memory (sets busy)
//   ld_valid/ld_rd/ld_data             load response, always consumed
//   RegWrite/addD/WB_out               registered register-file write port
//   busy                               bit i: load to xi outstanding (bit 0 = 0)
//   err                                sticky: load response for a non-busy rd
module regfile_wb_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            RegWrite,
  output logic [4:0]      addD,
  output logic [XLEN-1:0] WB_out,
  output logic [31:0]     busy,
  output logic            err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  // ALU result FIFO
  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            reg_write_q, reg_write_d;
  logic [4:0]      add_d_q, add_d_d;
  logic [XLEN-1:0] wb_out_q, wb_out_d;
  logic [31:0]     busy_q, busy_d;
  logic            err_q, err_d;

  logic            alu_acc;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            win_valid;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  assign alu_ready  = (cnt_q < DepthCnt);
  assign alu_acc    = alu_valid && alu_ready;
  assign fifo_empty = (cnt_q == '0);

  // Bypass only when nothing older is queued and no load takes the slot.
  assign push = alu_acc && (!fifo_empty || ld_valid);
  assign pop  = !ld_valid && !fifo_empty;

  always_comb begin
    win_valid = 1'b0;
    win_rd    = '0;
    win_data  = '0;
    if (ld_valid) begin
      win_valid = 1'b1;
      win_rd    = ld_rd;
      win_data  = ld_data;
    end else if (!fifo_empty) begin
      win_valid = 1'b1;
      win_rd    = fifo_rd_q[rd_ptr_q];
      win_data  = fifo_data_q[rd_ptr_q];
    end else if (alu_acc) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_data  = alu_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    // rd==0 still consumes its slot but never asserts the write enable.
    reg_write_d = win_valid && (win_rd != 5'd0);
    add_d_d     = win_valid ? win_rd : add_d_q;
    wb_out_d    = win_valid ? win_data : wb_out_q;
  end

  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (ld_valid && (ld_rd != 5'd0)) begin
      if (!busy_q[ld_rd]) begin
        err_d = 1'b1;
      end
      busy_d[ld_rd] = 1'b0;
    end
    // Applied after the clear so a same-cycle issue keeps the register busy.
    if (ld_issue && (ld_issue_rd != 5'd0)) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      reg_write_q <= 1'b0;
      add_d_q     <= '0;
      wb_out_q    <= '0;
      busy_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) begin
        fifo_rd_q[wr_ptr_q]   <= alu_rd;
        fifo_data_q[wr_ptr_q] <= alu_data;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      reg_write_q <= reg_write_d;
      add_d_q     <= add_d_d;
      wb_out_q    <= wb_out_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign RegWrite = reg_write_q;
  assign addD     = add_d_q;
  assign WB_out   = wb_out_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
